// File: rtl/calc_exec_unit.sv
// rtl/calc_exec_unit.sv - sequential signed add/sub/mul/div unit; optional divider under CALC_DIV_EN
module calc_exec_unit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic               a_neg,
  input  logic [WIDTH-1:0]   b_mag,
  input  logic               b_neg,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] res_mag,
  output logic               res_neg,
  output logic [WIDTH-1:0]   rem_mag,
  output logic               err
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDSUB,
    S_MUL,
    S_DIV,
    S_FIN
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  // a_q doubles as dividend/quotient shift register, b_q as multiplier shift register
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               an_q, an_d;
  logic               bn_q, bn_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic               neg_q, neg_d;
  logic               err_pend_q, err_pend_d;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] res_mag_q, res_mag_d;
  logic               res_neg_q, res_neg_d;
  logic [WIDTH-1:0]   rem_mag_q, rem_mag_d;
  logic               err_q, err_d;

  logic               a_neg_n;
  logic               b_neg_n;
  logic               eff_bn;

`ifdef CALC_DIV_EN
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH:0]     r_trial;
  logic [WIDTH-1:0]   q_trial;
`endif

  assign busy    = busy_q;
  assign done    = done_q;
  assign res_mag = res_mag_q;
  assign res_neg = res_neg_q;
  assign rem_mag = rem_mag_q;
  assign err     = err_q;

  // Next-state, datapath iteration and result formatting
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    an_d       = an_q;
    bn_d       = bn_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    neg_d      = neg_q;
    err_pend_d = err_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    res_mag_d  = res_mag_q;
    res_neg_d  = res_neg_q;
    rem_mag_d  = rem_mag_q;
    err_d      = err_q;
    // negative zero on an input is folded to +0 before it reaches any sign logic
    a_neg_n    = a_neg & (|a_mag);
    b_neg_n    = b_neg & (|b_mag);
    eff_bn     = bn_q ^ (op_q == OP_SUB);
`ifdef CALC_DIV_EN
    rem_d      = rem_q;
    r_trial    = {rem_q, a_q[WIDTH-1]};
    q_trial    = {a_q[WIDTH-2:0], 1'b0};
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d       = op;
          a_d        = a_mag;
          an_d       = a_neg_n;
          b_d        = b_mag;
          bn_d       = b_neg_n;
          cnt_d      = '0;
          acc_d      = '0;
          mcand_d    = {{WIDTH{1'b0}}, a_mag};
          neg_d      = a_neg_n ^ b_neg_n;
          err_pend_d = 1'b0;
          busy_d     = 1'b1;
`ifdef CALC_DIV_EN
          rem_d      = '0;
`endif
          // error cases ride through ADDSUB so they complete with the same latency as add
          case (op)
            OP_ADD, OP_SUB: state_d = S_ADDSUB;
            OP_MUL:         state_d = S_MUL;
`ifdef CALC_DIV_EN
            OP_DIV: begin
              if (|b_mag) begin
                state_d = S_DIV;
              end else begin
                err_pend_d = 1'b1;
                state_d    = S_ADDSUB;
              end
            end
`endif
            default: begin
              err_pend_d = 1'b1;
              state_d    = S_ADDSUB;
            end
          endcase
        end
      end

      S_ADDSUB: begin
        if (!err_pend_q) begin
          if (an_q == eff_bn) begin
            acc_d = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
            neg_d = an_q;
          end else if (a_q > b_q) begin
            acc_d = {{WIDTH{1'b0}}, a_q - b_q};
            neg_d = an_q;
          end else if (b_q > a_q) begin
            acc_d = {{WIDTH{1'b0}}, b_q - a_q};
            neg_d = eff_bn;
          end else begin
            acc_d = '0;
            neg_d = 1'b0;
          end
        end
        state_d = S_FIN;
      end

      S_MUL: begin
        // LSB-first shift-add; the cycle after the last iteration just hands off to FIN
        if (cnt_q == CW'(WIDTH)) begin
          state_d = S_FIN;
        end else begin
          if (b_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
          b_d     = {1'b0, b_q[WIDTH-1:1]};
          cnt_d   = cnt_q + 1'b1;
        end
      end

`ifdef CALC_DIV_EN
      S_DIV: begin
        // restoring divide: quotient bits enter a_q from the right as the dividend shifts out
        if (cnt_q == CW'(WIDTH)) begin
          acc_d   = {{WIDTH{1'b0}}, a_q};
          state_d = S_FIN;
        end else begin
          if (r_trial >= {1'b0, b_q}) begin
            r_trial    = r_trial - {1'b0, b_q};
            q_trial[0] = 1'b1;
          end
          rem_d = r_trial[WIDTH-1:0];
          a_d   = q_trial;
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (err_pend_q) begin
          res_mag_d = '0;
          res_neg_d = 1'b0;
          rem_mag_d = '0;
          err_d     = 1'b1;
        end else begin
          res_mag_d = acc_q;
          res_neg_d = neg_q & (|acc_q);
`ifdef CALC_DIV_EN
          rem_mag_d = (op_q == OP_DIV) ? rem_q : '0;
`else
          rem_mag_d = '0;
`endif
          err_d     = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation without a done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      an_q       <= 1'b0;
      bn_q       <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      neg_q      <= 1'b0;
      err_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_mag_q  <= '0;
      res_neg_q  <= 1'b0;
      rem_mag_q  <= '0;
      err_q      <= 1'b0;
`ifdef CALC_DIV_EN
      rem_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      an_q       <= an_d;
      bn_q       <= bn_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      neg_q      <= neg_d;
      err_pend_q <= err_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      res_mag_q  <= res_mag_d;
      res_neg_q  <= res_neg_d;
      rem_mag_q  <= rem_mag_d;
      err_q      <= err_d;
`ifdef CALC_DIV_EN
      rem_q      <= rem_d;
`endif
    end
  end

endmodule

// File: tb/tb_calc_exec_unit.sv
// tb/tb_calc_exec_unit.sv - directed self-checking bench for calc_exec_unit
module tb_calc_exec_unit;

  localparam int WIDTH = 8;

  logic               clk;
  logic               reset;
  logic               start;
  logic [2:0]         op;
  logic [WIDTH-1:0]   a_mag;
  logic               a_neg;
  logic [WIDTH-1:0]   b_mag;
  logic               b_neg;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] res_mag;
  logic               res_neg;
  logic [WIDTH-1:0]   rem_mag;
  logic               err;

  int n_cmp;
  int n_bad;

  calc_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a_mag   (a_mag),
    .a_neg   (a_neg),
    .b_mag   (b_mag),
    .b_neg   (b_neg),
    .busy    (busy),
    .done    (done),
    .res_mag (res_mag),
    .res_neg (res_neg),
    .rem_mag (rem_mag),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one transaction: start at a negedge, sampled at E0, then wait for done and check everything
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [7:0] a, input logic an,
                        input logic [7:0] b, input logic bn,
                        input int exp_l, input logic [15:0] exp_res,
                        input logic exp_neg, input logic [7:0] exp_rem,
                        input logic exp_err);
    int  lat;
    bit  seen;
    bit  busy_ok;
    @(negedge clk);
    op = o; a_mag = a; a_neg = an; b_mag = b; b_neg = bn; start = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".busy_e0"}, 32'(busy), 32'd1);
    chk({tag, ".done_e0"}, 32'(done), 32'd0);
    @(negedge clk);
    start = 1'b0;
    // scramble operands while busy; the unit must ignore them
    op = ~o; a_mag = ~a; a_neg = ~an; b_mag = ~b; b_neg = ~bn;
    lat = 0; seen = 0; busy_ok = 1;
    for (int i = 1; i <= 30 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1;
        lat  = i;
      end else if (!busy) begin
        busy_ok = 0;
      end
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_l));
    chk({tag, ".busy_during"}, 32'(busy_ok), 32'd1);
    chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, ".res_mag"}, 32'(res_mag), 32'(exp_res));
    chk({tag, ".res_neg"}, 32'(res_neg), 32'(exp_neg));
    chk({tag, ".rem_mag"}, 32'(rem_mag), 32'(exp_rem));
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    int dones;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1; start = 1'b0; op = '0;
    a_mag = '0; a_neg = 1'b0; b_mag = '0; b_neg = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.res_mag", 32'(res_mag), 32'd0);
    chk("rst.res_neg", 32'(res_neg), 32'd0);
    chk("rst.rem_mag", 32'(rem_mag), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    //      tag        op      a    an  b    bn  L   res     neg rem err
    run_op("add",     3'b000, 200, 0, 100, 0, 2,  16'd300,   0, 0, 0);
    run_op("sub_neg", 3'b001, 5,   0, 9,   0, 2,  16'd4,     1, 0, 0);
    run_op("sub_tie", 3'b001, 5,   1, 5,   1, 2,  16'd0,     0, 0, 0);
    run_op("add_mix", 3'b000, 3,   1, 10,  0, 2,  16'd7,     0, 0, 0);
    run_op("sub_nz",  3'b001, 0,   1, 3,   0, 2,  16'd3,     1, 0, 0);
    run_op("mul",     3'b010, 255, 1, 255, 0, 10, 16'hFE01,  1, 0, 0);
    run_op("mul_zero",3'b010, 5,   1, 0,   0, 10, 16'd0,     0, 0, 0);
`ifdef CALC_DIV_EN
    run_op("div",     3'b011, 200, 0, 7,   1, 10, 16'd28,    1, 4, 0);
    run_op("div_exact",3'b011,96,  1, 12,  1, 10, 16'd8,     0, 0, 0);
`else
    run_op("div_off", 3'b011, 8,   0, 2,   0, 2,  16'd0,     0, 0, 1);
`endif
    run_op("div0",    3'b011, 9,   0, 0,   0, 2,  16'd0,     0, 0, 1);
    run_op("err_clr", 3'b000, 1,   0, 1,   0, 2,  16'd2,     0, 0, 0);
    run_op("inval",   3'b100, 4,   0, 4,   0, 2,  16'd0,     0, 0, 1);
    run_op("mul_small",3'b010,3,   0, 4,   0, 10, 16'd12,    0, 0, 0);

    // start pulsed mid-multiply must be ignored
    @(negedge clk);
    op = 3'b010; a_mag = 8'd6; a_neg = 1'b0; b_mag = 8'd7; b_neg = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    op = 3'b000; a_mag = 8'd1; b_mag = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("ign.dones", 32'(dones), 32'd1);
    chk("ign.res_mag", 32'(res_mag), 32'd42);

    // reset sampled at E0+4 of a multiply aborts it and clears outputs
    @(negedge clk);
    op = 3'b010; a_mag = 8'd7; b_mag = 8'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.res_mag", 32'(res_mag), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("abort.no_done", 32'(dones), 32'd0);

    run_op("post_rst",3'b000, 200, 1, 100, 0, 2,  16'd100,   1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
